// File: rtl/ring_chaser_monitor.sv
// Receive-side monitor for a walking-one ring: synchronizes and deglitches the ring,
// tracks position, checks forward steps, counts revolutions and flags faults/stalls.
module ring_chaser_monitor #(
    parameter  int WIDTH       = 6,
    parameter  int SYNC_STAGES = 2,
    parameter  int CNT_W       = 8,
    parameter  int STALL_W     = 10,
    localparam int IDX_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clear,
    output logic [IDX_W-1:0] index,
    output logic             locked,
    output logic             step,
    output logic             wrap,
    output logic [CNT_W-1:0] rev_count,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             stall
);

    typedef enum logic [1:0] {S_ACQUIRE, S_TRACK, S_FAULT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   sync;
    logic [WIDTH-1:0]   sync_dly_q;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic [1:0]         code_q, code_d;
    logic [CNT_W-1:0]   rev_q, rev_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;

    logic               accept;
    logic               onehot;
    logic               allzero;
    logic               legal;
    logic [IDX_W-1:0]   pos;
    logic [IDX_W-1:0]   next_idx;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_q[gi] <= '0;
                    else        sync_q[gi] <= ring_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_q[gi] <= '0;
                    else        sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign sync     = sync_q[SYNC_STAGES-1];
    // A candidate is taken only after it has been seen on two consecutive samples.
    assign accept   = (sync == sync_dly_q) && (sync != acc_q);
    assign onehot   = $onehot(sync);
    assign allzero  = (sync == '0);
    assign next_idx = (index_q == IDX_W'(WIDTH-1)) ? '0 : index_q + 1'b1;
    assign legal    = onehot && (pos == next_idx);

    always_comb begin
        pos = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (sync[k]) pos = IDX_W'(k);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_ACQUIRE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_ACQUIRE;
        end else begin
            case (state_q)
                S_ACQUIRE: if (accept && onehot) state_d = S_TRACK;
                S_TRACK:   if (accept && !legal) state_d = S_FAULT;
                default:   state_d = S_FAULT;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        acc_d   = (accept && !clear) ? sync : acc_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        index_d = index_q;
        code_d  = code_q;
        rev_d   = rev_q;
        cnt_d   = '0;
        if (clear) begin
            index_d = '0;
            code_d  = 2'b00;
            rev_d   = '0;
        end else begin
            case (state_q)
                S_ACQUIRE: begin
                    if (accept && onehot) index_d = pos;
                end
                S_TRACK: begin
                    if (accept) begin
                        if (legal) begin
                            step_d  = 1'b1;
                            index_d = pos;
                            if (pos == '0) begin
                                wrap_d = 1'b1;
                                rev_d  = rev_q + 1'b1;
                            end
                        end else if (allzero) begin
                            code_d = 2'b11;
                        end else if (onehot) begin
                            code_d = 2'b10;
                        end else begin
                            code_d = 2'b01;
                        end
                    end else begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dly_q <= '0;
            acc_q      <= '0;
            index_q    <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            code_q     <= 2'b00;
            rev_q      <= '0;
            cnt_q      <= '0;
        end else begin
            sync_dly_q <= sync;
            acc_q      <= acc_d;
            index_q    <= index_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            code_q     <= code_d;
            rev_q      <= rev_d;
            cnt_q      <= cnt_d;
        end
    end

    // Output logic
    always_comb begin
        locked     = (state_q == S_TRACK);
        fault      = (state_q == S_FAULT);
        stall      = (state_q == S_TRACK) && (cnt_q == '1);
        index      = index_q;
        step       = step_q;
        wrap       = wrap_q;
        fault_code = code_q;
        rev_count  = rev_q;
    end

endmodule

// File: tb/tb_ring_chaser_monitor.sv
// Scoreboard bench for ring_chaser_monitor: stimulus queues expected output events,
// a negedge monitor pops and compares each time the DUT presents an event.
module tb_ring_chaser_monitor;

    localparam int WIDTH       = 6;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int STALL_W     = 10;
    localparam int IDX_W       = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic [WIDTH-1:0] ring_in;
    logic [IDX_W-1:0] index;
    logic             locked;
    logic             step;
    logic             wrap;
    logic [CNT_W-1:0] rev_count;
    logic             fault;
    logic [1:0]       fault_code;
    logic             stall;

    ring_chaser_monitor #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .STALL_W(STALL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .clear(clear),
        .index(index), .locked(locked), .step(step), .wrap(wrap),
        .rev_count(rev_count), .fault(fault), .fault_code(fault_code), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       step;
        logic       wrap;
        logic [2:0] idx;
        logic       locked;
        logic       fault;
        logic [1:0] code;
        logic       stall;
        logic [7:0] rev;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  snap_cnt = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic st, input logic wr, input logic [2:0] ix,
                        input logic lk, input logic ft, input logic [1:0] cd,
                        input logic sl, input logic [7:0] rv);
        ev_t e;
        e.cyc = c; e.step = st; e.wrap = wr; e.idx = ix; e.locked = lk;
        e.fault = ft; e.code = cd; e.stall = sl; e.rev = rv;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [WIDTH-1:0] p, input int hold);
        ring_in = p;
        tick(hold);
    endtask

    task automatic do_clear();
        push(cyc + 1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(4);
    endtask

    // Monitor: an event is a step pulse, a change of locked/fault/stall, or a snapshot request.
    initial begin : monitor
        logic p_lk;
        logic p_ft;
        logic p_sl;
        int   seen;
        bit   fire;
        ev_t  e;
        p_lk = 1'b0; p_ft = 1'b0; p_sl = 1'b0; seen = 0;
        forever begin
            @(negedge clk);
            fire = (step === 1'b1) || (locked !== p_lk) || (fault !== p_ft) ||
                   (stall !== p_sl) || (seen != snap_cnt);
            seen = snap_cnt;
            p_lk = locked; p_ft = fault; p_sl = stall;
            if (fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d step=%b wrap=%b idx=%0d locked=%b fault=%b code=%b stall=%b rev=%0d required=none",
                             cyc, step, wrap, index, locked, fault, fault_code, stall, rev_count);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.step !== step || e.wrap !== wrap || e.idx !== index ||
                        e.locked !== locked || e.fault !== fault || e.code !== fault_code ||
                        e.stall !== stall || e.rev !== rev_count) begin
                        errors++;
                        $display("FAIL event got cyc=%0d step=%b wrap=%b idx=%0d locked=%b fault=%b code=%b stall=%b rev=%0d | required cyc=%0d step=%b wrap=%b idx=%0d locked=%b fault=%b code=%b stall=%b rev=%0d",
                                 cyc, step, wrap, index, locked, fault, fault_code, stall, rev_count,
                                 e.cyc, e.step, e.wrap, e.idx, e.locked, e.fault, e.code, e.stall, e.rev);
                    end else begin
                        $display("ok event cyc=%0d step=%b wrap=%b idx=%0d locked=%b fault=%b code=%b stall=%b rev=%0d",
                                 cyc, step, wrap, index, locked, fault, fault_code, stall, rev_count);
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] pat   [8] = '{6'b100000, 6'b000001, 6'b000010, 6'b000100,
                                    6'b001000, 6'b010000, 6'b100000, 6'b000001};
    logic             e_st  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic             e_wr  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]       e_ix  [8] = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [7:0]       e_rv  [8] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};

    initial begin : stimulus
        int d;
        rst_n   = 1'b0;
        clear   = 1'b0;
        ring_in = '0;
        tick(2);
        push(cyc, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        snap_cnt++;
        tick(1);
        rst_n = 1'b1;

        // Idle all-zero ring: nothing should happen
        tick(100);
        push(cyc, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        snap_cnt++;
        tick(1);

        // Full chase with two wraps; every event lands 4 edges after the change
        for (int i = 0; i < 8; i++) begin
            push(cyc + 4, e_st[i], e_wr[i], e_ix[i], 1'b1, 1'b0, 2'b00, 1'b0, e_rv[i]);
            drive(pat[i], 8);
        end

        // Skip 1 -> 3 is an illegal jump; clear then re-acquire at position 4
        push(cyc + 4, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 2'b00, 1'b0, 8'd2);
        drive(6'b000010, 8);
        push(cyc + 4, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 2'b10, 1'b0, 8'd2);
        drive(6'b001000, 8);
        do_clear();
        push(cyc + 4, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        drive(6'b010000, 8);

        // Multi-hot fault
        push(cyc + 4, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        drive(6'b100000, 8);
        push(cyc + 4, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
        drive(6'b000110, 8);
        do_clear();

        // All-zero while locked
        push(cyc + 4, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        drive(6'b000001, 8);
        push(cyc + 4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b11, 1'b0, 8'd0);
        drive(6'b000000, 8);
        do_clear();
        push(cyc + 4, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        drive(6'b000001, 8);

        // Single-cycle glitch is filtered, then hold long enough to stall
        drive(6'b000011, 1);
        d = cyc;
        push(d + 4, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        push(d + 4 + 1023, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 2'b00, 1'b1, 8'd0);
        drive(6'b000010, 1040);
        push(cyc + 4, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
        drive(6'b000100, 8);

        // Asynchronous reset between edges: outputs drop before the next clock
        #1;
        push(cyc, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
        rst_n = 1'b0;
        tick(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
